// File: rtl/piezo_seq_if.sv
// Control/status bundle between the alarm controller (master) and the
// table-driven piezo sequencer (slave).
interface piezo_seq_if #(
  parameter int DEPTH = 8,
  parameter int PER_W = 15,
  parameter int DUR_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic             stop;
  logic             loop;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [PER_W-1:0] wr_per;
  logic [DUR_W-1:0] wr_dur;
  logic             piezo;
  logic             piezo_n;
  logic             busy;
  logic             done;
  logic [AW-1:0]    note_idx;
  logic [7:0]       loop_cnt;
  logic [1:0]       state;

  modport master (
    output start, stop, loop, wr_en, wr_addr, wr_per, wr_dur,
    input  piezo, piezo_n, busy, done, note_idx, loop_cnt, state
  );

  modport slave (
    input  start, stop, loop, wr_en, wr_addr, wr_per, wr_dur,
    output piezo, piezo_n, busy, done, note_idx, loop_cnt, state
  );
endinterface

// File: rtl/piezo_seq.sv
// Table-driven piezo note sequencer: plays up to DEPTH {period, duration}
// entries one-shot or looping, and drives complementary piezo pins.
module piezo_seq #(
  parameter int DEPTH    = 8,
  parameter int PER_W    = 15,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 500000
) (
  input logic        clk,
  input logic        rst_n,
  piezo_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01
  } state_e;

  logic [PER_W-1:0] perMem_q [DEPTH];
  logic [DUR_W-1:0] durMem_q [DEPTH];

  state_e           state_q,   state_d;
  logic [AW-1:0]    noteIdx_q, noteIdx_d;
  logic [PER_W-1:0] curPer_q,  curPer_d;
  logic [DUR_W-1:0] curDur_q,  curDur_d;
  logic [TW-1:0]    tickCnt_q, tickCnt_d;
  logic [DUR_W-1:0] durCnt_q,  durCnt_d;
  logic [PER_W-1:0] perCnt_q,  perCnt_d;
  logic             loop_q,    loop_d;
  logic [7:0]       loopCnt_q, loopCnt_d;
  logic             done_q,    done_d;

  logic             tickWrap;
  logic             noteOver;
  logic [AW-1:0]    nxtIdx;
  logic             fetchEn;
  logic [AW-1:0]    fetchIdx;
  logic             toIdle;
  logic             toneHi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        perMem_q[i] <= '0;
        durMem_q[i] <= '0;
      end
    end else if (bus.wr_en) begin
      perMem_q[bus.wr_addr] <= bus.wr_per;
      durMem_q[bus.wr_addr] <= bus.wr_dur;
    end
  end

  assign tickWrap = (tickCnt_q == TW'(TICK_DIV - 1));
  assign noteOver = tickWrap && (durCnt_q == curDur_q - DUR_W'(1));
  assign nxtIdx   = noteIdx_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    noteIdx_d = noteIdx_q;
    curPer_d  = curPer_q;
    curDur_d  = curDur_q;
    tickCnt_d = tickCnt_q;
    durCnt_d  = durCnt_q;
    perCnt_d  = perCnt_q;
    loop_d    = loop_q;
    loopCnt_d = loopCnt_q;
    done_d    = 1'b0;
    fetchEn   = 1'b0;
    fetchIdx  = '0;
    toIdle    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          loop_d = bus.loop;
          if (durMem_q[0] == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = PLAY;
            fetchEn   = 1'b1;
            loopCnt_d = '0;
          end
        end
      end
      PLAY: begin
        tickCnt_d = tickWrap ? '0 : tickCnt_q + TW'(1);
        if (tickWrap) durCnt_d = durCnt_q + DUR_W'(1);
        perCnt_d = (curPer_q == '0 || perCnt_q == curPer_q - PER_W'(1))
                   ? '0 : perCnt_q + PER_W'(1);
        if (noteOver) begin
          // Reaching the last table slot ends the pass even if slot 0 is valid.
          if (durMem_q[nxtIdx] != '0 && noteIdx_q != AW'(DEPTH - 1)) begin
            fetchEn  = 1'b1;
            fetchIdx = nxtIdx;
          end else if (loop_q) begin
            if (loopCnt_q != 8'hFF) loopCnt_d = loopCnt_q + 8'd1;
            if (durMem_q[0] != '0) fetchEn = 1'b1;
            else begin
              toIdle = 1'b1;
              done_d = 1'b1;
            end
          end else begin
            toIdle = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      default: toIdle = 1'b1;
    endcase

    if (bus.stop) begin
      fetchEn = 1'b0;
      toIdle  = 1'b1;
      done_d  = 1'b0;
    end

    if (fetchEn) begin
      noteIdx_d = fetchIdx;
      curPer_d  = perMem_q[fetchIdx];
      curDur_d  = durMem_q[fetchIdx];
      tickCnt_d = '0;
      durCnt_d  = '0;
      perCnt_d  = '0;
    end

    if (toIdle) begin
      state_d   = IDLE;
      noteIdx_d = '0;
      curPer_d  = '0;
      curDur_d  = '0;
      tickCnt_d = '0;
      durCnt_d  = '0;
      perCnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      noteIdx_q <= '0;
      curPer_q  <= '0;
      curDur_q  <= '0;
      tickCnt_q <= '0;
      durCnt_q  <= '0;
      perCnt_q  <= '0;
      loop_q    <= 1'b0;
      loopCnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      noteIdx_q <= noteIdx_d;
      curPer_q  <= curPer_d;
      curDur_q  <= curDur_d;
      tickCnt_q <= tickCnt_d;
      durCnt_q  <= durCnt_d;
      perCnt_q  <= perCnt_d;
      loop_q    <= loop_d;
      loopCnt_q <= loopCnt_d;
      done_q    <= done_d;
    end
  end

  // A rest (period 0) and IDLE both leave the two pins low.
  assign toneHi       = (state_q == PLAY) && (curPer_q != '0) && (perCnt_q < (curPer_q >> 1));
  assign bus.piezo    = toneHi;
  assign bus.piezo_n  = (state_q == PLAY) && (curPer_q != '0) && !toneHi;
  assign bus.busy     = (state_q == PLAY);
  assign bus.done     = done_q;
  assign bus.note_idx = noteIdx_q;
  assign bus.loop_cnt = loopCnt_q;
  assign bus.state    = state_q;
endmodule
